// File: rtl/instruction_fetch_unit_if.sv
// Bundle of control, ROM-port and instruction-stream signals for instruction_fetch_unit.
// The fetch unit takes the master modport; the ROM/core/controller side takes slave.
interface instruction_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 12
);
  logic                  start;
  logic [31:0]           base_addr;
  logic [CNT_WIDTH-1:0]  num_instr;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic [31:0]           rom_addra;
  logic                  rom_en;
  logic [DATA_WIDTH-1:0] rom_dout;
  // Stream: a word moves on a cycle with instr_valid && instr_ready. Once valid
  // is raised, instr_data/instr_addr hold and valid stays up until the transfer;
  // only flush or rst may retract it. Ready may toggle freely.
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [31:0]           instr_addr;
  logic [1:0]            dbg_state;

  modport master (
    input  start, base_addr, num_instr, flush, rom_dout, instr_ready,
    output busy, done, rom_addra, rom_en, instr_valid, instr_data, instr_addr, dbg_state
  );

  modport slave (
    output start, base_addr, num_instr, flush, rom_dout, instr_ready,
    input  busy, done, rom_addra, rom_en, instr_valid, instr_data, instr_addr, dbg_state
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Burst reader for the instruction ROM: issues credit-limited reads, buffers the
// returned words in a small prefetch FIFO and streams them out with their addresses.
module instruction_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ROM_DEPTH  = 2048,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_unit_if.master   bus
);
  localparam int AW = $clog2(ROM_DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issued;
  logic [AW-1:0]         next_addr;
  logic [AW-1:0]         rom_addr_q;
  logic                  rom_en_q;
  logic                  done_q;
  logic                  inflight;
  logic [AW-1:0]         inflight_addr;

  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [AW-1:0]         addr_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fifo_count;

  logic                  valid;
  logic                  pop;
  logic                  push;
  logic                  can_issue;
  logic [7:0]            credit_used;
  logic                  unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid = (fifo_count != '0);
  assign pop   = valid && bus.instr_ready;
  assign push  = inflight && !bus.flush && !rst;

  // Words already buffered plus reads whose data has yet to land; the word
  // leaving this cycle frees its slot before the new read can return.
  assign credit_used = 8'(fifo_count) + 8'(rom_en_q) + 8'(inflight) - 8'(pop);
  assign can_issue   = (issued != num_q) && (credit_used < 8'(FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      num_q         <= '0;
      issued        <= '0;
      next_addr     <= '0;
      rom_addr_q    <= '0;
      rom_en_q      <= 1'b0;
      done_q        <= 1'b0;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
    end else if (bus.flush) begin
      // The read launched this cycle returns next cycle with inflight cleared, so it is dropped.
      state      <= IDLE;
      issued     <= '0;
      rom_en_q   <= 1'b0;
      done_q     <= 1'b0;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      done_q        <= 1'b0;
      rom_en_q      <= 1'b0;
      inflight      <= rom_en_q;
      inflight_addr <= rom_addr_q;
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);

      case (state)
        IDLE: begin
          if (bus.start) begin
            num_q <= bus.num_instr;
            if (bus.num_instr == '0) begin
              done_q <= 1'b1;
            end else begin
              rom_en_q   <= 1'b1;
              rom_addr_q <= bus.base_addr[AW-1:0];
              next_addr  <= bus.base_addr[AW-1:0] + 1'b1;
              issued     <= CNT_WIDTH'(1);
              state      <= (bus.num_instr == CNT_WIDTH'(1)) ? DRAIN : FETCH;
            end
          end
        end
        FETCH: begin
          if (can_issue) begin
            rom_en_q   <= 1'b1;
            rom_addr_q <= next_addr;
            next_addr  <= next_addr + 1'b1;
            issued     <= issued + CNT_WIDTH'(1);
            if (issued + CNT_WIDTH'(1) == num_q) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && fifo_count == CW'(1) && !inflight && !rom_en_q) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.rom_dout;
      addr_mem[wr_ptr] <= inflight_addr;
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.rom_en      = rom_en_q;
  assign bus.rom_addra   = 32'(rom_addr_q);
  assign bus.instr_valid = valid;
  assign bus.instr_data  = valid ? data_mem[rd_ptr] : '0;
  assign bus.instr_addr  = valid ? 32'(addr_mem[rd_ptr]) : '0;
  assign bus.dbg_state   = state;
  assign unused_bits     = ^bus.base_addr[31:AW];
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: ROM model, burst driver/monitor and a
// reference queue of {address, data} pairs derived from the burst parameters.
module tb_instruction_fetch_unit;
  localparam int DW = 32;
  localparam int RD = 2048;
  localparam int FD = 4;
  localparam int CW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

  instruction_fetch_unit #(
    .DATA_WIDTH(DW), .ROM_DEPTH(RD), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic [DW-1:0] rom [RD];
  always @(posedge clk) if (bus.rom_en) bus.rom_dout <= rom[bus.rom_addra[10:0]];

  int total = 0;
  int bad   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  int first_valid_k, first_en_k, done_count, done_k, rom_en_count, max_out;
  int stable_viol, xfer_cnt, first_xfer_k, last_xfer_k, flush_k;
  logic busy_at_done, busy_seen, valid_after_flush, busy_after_flush;

  // Reference model: burst of n words from base, addresses wrapping modulo the ROM size.
  task automatic build_exp(input int base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      int a;
      a = (base + i) % RD;
      exp_q.push_back({32'(a), rom[a]});
    end
  endtask

  // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: random ready.
  task automatic run_burst(input int base, input int n, input int mode,
                           input int flush_at, input int restart_k, input int budget);
    int k, stop_k, issued_obs;
    logic rdy, pv, pr;
    logic [31:0] pd, pa;
    obs_q.delete();
    first_valid_k = -1; first_en_k = -1; done_count = 0; done_k = -1;
    rom_en_count = 0; max_out = 0; stable_viol = 0; xfer_cnt = 0;
    first_xfer_k = -1; last_xfer_k = -1; flush_k = -1;
    busy_at_done = 1'b1; busy_seen = 1'b0; valid_after_flush = 1'b1; busy_after_flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 32'(base); bus.num_instr = 12'(n); bus.instr_ready = 1'b0;
    k = 0; stop_k = budget; issued_obs = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; pa = '0;
    while (k < stop_k) begin
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      bus.flush = 1'b0;
      if (k == restart_k) begin
        bus.start = 1'b1; bus.base_addr = 32'd1234; bus.num_instr = 12'd7;
      end
      if (bus.rom_en) begin
        rom_en_count++;
        issued_obs++;
        if (first_en_k < 0) first_en_k = k;
      end
      if (bus.busy) busy_seen = 1'b1;
      if (bus.instr_valid && first_valid_k < 0) first_valid_k = k;
      if (bus.done) begin
        done_count++;
        if (done_k < 0) begin done_k = k; busy_at_done = bus.busy; end
      end
      if (flush_k >= 0 && k == flush_k + 1) begin
        valid_after_flush = bus.instr_valid; busy_after_flush = bus.busy;
      end
      if (pv && !pr && flush_k < 0 &&
          !(bus.instr_valid && bus.instr_data === pd && bus.instr_addr === pa)) stable_viol++;
      if (issued_obs - xfer_cnt > max_out) max_out = issued_obs - xfer_cnt;
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((k - 1) % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus.instr_ready = rdy;
      if (bus.instr_valid && rdy) begin
        obs_q.push_back({bus.instr_addr, bus.instr_data});
        xfer_cnt++;
        if (first_xfer_k < 0) first_xfer_k = k;
        last_xfer_k = k;
        if (xfer_cnt == flush_at) begin bus.flush = 1'b1; flush_k = k; stop_k = k + 6; end
      end
      if (bus.done && stop_k > k + 3) stop_k = k + 3;
      pv = bus.instr_valid; pr = rdy; pd = bus.instr_data; pa = bus.instr_addr;
    end
    bus.instr_ready = 1'b0; bus.start = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({bus.busy, bus.done, bus.rom_en, bus.instr_valid} !== 4'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {bus.busy, bus.done, bus.rom_en, bus.instr_valid}); end
    total++; if (bus.rom_addra !== 32'd0) begin bad++; $display("FAIL reset_rom_addra: got %h want 0", bus.rom_addra); end
    total++; if (bus.instr_data !== 32'd0) begin bad++; $display("FAIL reset_instr_data: got %h want 0", bus.instr_data); end
    total++; if (bus.instr_addr !== 32'd0) begin bad++; $display("FAIL reset_instr_addr: got %h want 0", bus.instr_addr); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    build_exp(0, 8);
    run_burst(0, 8, 0, 0, 0, 60);
    total++; if (first_en_k !== 1) begin bad++; $display("FAIL basic_rom_en_cycle: got %0d want 1", first_en_k); end
    total++; if (first_valid_k !== 3) begin bad++; $display("FAIL basic_valid_cycle: got %0d want 3", first_valid_k); end
    total++; if (obs_q.size() !== 8) begin bad++; $display("FAIL basic_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL basic_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (last_xfer_k - first_xfer_k !== 7) begin bad++; $display("FAIL basic_back_to_back: got span %0d want 7", last_xfer_k - first_xfer_k); end
    total++; if (done_k !== last_xfer_k + 1) begin bad++; $display("FAIL basic_done_cycle: got %0d want %0d", done_k, last_xfer_k + 1); end
    total++; if (done_count !== 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_count); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
  endtask

  task automatic test_wrap();
    build_exp(2045, 5);
    run_burst(2045, 5, 0, 0, 0, 50);
    total++; if (obs_q.size() !== 5) begin bad++; $display("FAIL wrap_count: got %0d want 5", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (done_count !== 1) begin bad++; $display("FAIL wrap_done_count: got %0d want 1", done_count); end
  endtask

  task automatic test_backpressure();
    build_exp(700, 16);
    run_burst(700, 16, 1, 0, 0, 120);
    total++; if (obs_q.size() !== 16) begin bad++; $display("FAIL bp_count: got %0d want 16", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL bp_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (stable_viol !== 0) begin bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", stable_viol); end
    total++; if (max_out > FD) begin bad++; $display("FAIL bp_outstanding: got %0d want <= %0d", max_out, FD); end
    total++; if (done_count !== 1) begin bad++; $display("FAIL bp_done_count: got %0d want 1", done_count); end
  endtask

  task automatic test_zero_len();
    run_burst(50, 0, 0, 0, 0, 10);
    total++; if (done_k !== 1) begin bad++; $display("FAIL zero_done_cycle: got %0d want 1", done_k); end
    total++; if (done_count !== 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_count); end
    total++; if (rom_en_count !== 0) begin bad++; $display("FAIL zero_rom_en: got %0d want 0", rom_en_count); end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", busy_seen); end
  endtask

  task automatic test_flush();
    build_exp(40, 10);
    run_burst(40, 10, 0, 3, 0, 60);
    total++; if (obs_q.size() !== 3) begin bad++; $display("FAIL flush_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 3; i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL flush_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (valid_after_flush !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", valid_after_flush); end
    total++; if (busy_after_flush !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy_after_flush); end
    total++; if (done_count !== 0) begin bad++; $display("FAIL flush_no_done: got %0d want 0", done_count); end
    build_exp(100, 4);
    run_burst(100, 4, 0, 0, 0, 40);
    total++; if (obs_q.size() !== 4) begin bad++; $display("FAIL refetch_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL refetch_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_rst_midburst();
    @(negedge clk);
    bus.start = 1'b1; bus.base_addr = 32'd500; bus.num_instr = 12'd10; bus.instr_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    total++; if ({bus.busy, bus.done, bus.rom_en, bus.instr_valid} !== 4'b0) begin
      bad++; $display("FAIL rst_flags: got %b want 0000", {bus.busy, bus.done, bus.rom_en, bus.instr_valid}); end
    total++; if ({bus.rom_addra, bus.instr_addr, bus.instr_data} !== 96'd0) begin
      bad++; $display("FAIL rst_buses: got %h %h %h want 0", bus.rom_addra, bus.instr_addr, bus.instr_data); end
    @(negedge clk);
    total++; if ({bus.busy, bus.done, bus.instr_valid} !== 3'b0) begin
      bad++; $display("FAIL rst_quiet: got %b want 000", {bus.busy, bus.done, bus.instr_valid}); end
    build_exp(300, 6);
    run_burst(300, 6, 1, 0, 4, 80);
    total++; if (obs_q.size() !== 6) begin bad++; $display("FAIL restart_count: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL restart_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (done_count !== 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", done_count); end
  endtask

  task automatic test_random();
    for (int b = 0; b < 6; b++) begin
      int base, n;
      base = int'($urandom_range(0, RD - 1));
      n    = int'($urandom_range(1, 30));
      build_exp(base, n);
      run_burst(base, n, 2, 0, 0, 4 * n + 40);
      total++; if (obs_q.size() !== n) begin bad++; $display("FAIL rand%0d_count: got %0d want %0d", b, obs_q.size(), n); end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
        total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL rand%0d_word%0d: got %h want %h", b, i, obs_q[i], exp_q[i]); end
      end
      total++; if (stable_viol !== 0) begin bad++; $display("FAIL rand%0d_stable: got %0d want 0", b, stable_viol); end
      total++; if (done_count !== 1) begin bad++; $display("FAIL rand%0d_done_count: got %0d want 1", b, done_count); end
    end
  endtask

  task automatic test_long_wrap();
    build_exp(2040, 2051);
    run_burst(2040, 2051, 0, 0, 0, 2051 + 40);
    total++; if (obs_q.size() !== 2051) begin bad++; $display("FAIL long_count: got %0d want 2051", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      total++; if (obs_q[i] !== exp_q[i]) begin bad++; $display("FAIL long_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    total++; if (last_xfer_k - first_xfer_k !== 2050) begin bad++; $display("FAIL long_throughput: got span %0d want 2050", last_xfer_k - first_xfer_k); end
  endtask

  initial begin
    for (int i = 0; i < RD; i++) rom[i] = $urandom;
    bus.start = 1'b0; bus.base_addr = '0; bus.num_instr = '0;
    bus.flush = 1'b0; bus.instr_ready = 1'b0; bus.rom_dout = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_flush();
    test_rst_midburst();
    test_random();
    test_long_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
